// File: rtl/mips_defs.sv
// mips_defs: opcode/funct encodings, reset PC and field widths shared by the decode stage.
package mips_defs;
  localparam int OP_W = 6;
  localparam int FN_W = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int IDX_W = 26;
  localparam int NUM_REGS = 32;
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0] OP_J = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE = 6'b000101;
  localparam logic [FN_W-1:0] FN_JR = 6'b001000;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/grf.sv
// grf: 32x32 register file, sync active-low clear, one write port, two write-through read ports.
module grf #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs_q [NUM_REGS];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we && wa != '0) begin
      regs_q[wa] <= wd;
    end
  end
  // reg 0 is never written, so it always reads 0 from the array
  assign rd1 = (we && wa == ra1 && ra1 != '0) ? wd : regs_q[ra1];
  assign rd2 = (we && wa == ra2 && ra2 != '0) ? wd : regs_q[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage - IF/ID register, GRF with MEM forwarding, branch/jump next-PC resolution.
module id_stage #(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        m_fwd_we,
  input  logic [4:0]  m_fwd_addr,
  input  logic [31:0] m_fwd_data,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_rs_data,
  output logic [31:0] d_rt_data,
  output logic [31:0] next_pc
);
  import mips_defs::*;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic [31:0] grf_rs, grf_rt, base, br_tgt;
  logic [REG_W-1:0] rs, rt;
  logic [OP_W-1:0] op;
  logic [FN_W-1:0] fn;
  logic [IMM_W-1:0] imm;
  logic taken;
  always_comb begin
    instr_d = !reset ? '0 : stall ? instr_q : f_instr;
    pc_d = !reset ? RESET_PC : stall ? pc_q : f_pc;
  end
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q <= pc_d;
  end
  assign d_instr = instr_q;
  assign d_pc = pc_q;
  assign op = instr_q[31:26];
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign imm = instr_q[15:0];
  assign fn = instr_q[5:0];
  grf #(.NUM_REGS(NUM_REGS)) u_grf (
    .clk(clk), .reset(reset), .we(w_we), .wa(w_addr), .wd(w_data),
    .ra1(rs), .ra2(rt), .rd1(grf_rs), .rd2(grf_rt)
  );
  // MEM result is younger than WB, so it wins when both target the same reg
  assign d_rs_data = rs == '0 ? '0 : (m_fwd_we && m_fwd_addr == rs) ? m_fwd_data : grf_rs;
  assign d_rt_data = rt == '0 ? '0 : (m_fwd_we && m_fwd_addr == rt) ? m_fwd_data : grf_rt;
  assign base = pc_q + 32'd4;
  assign br_tgt = base + {{14{imm[15]}}, imm, 2'b00};
  assign taken = (op == OP_BEQ && d_rs_data == d_rt_data) || (op == OP_BNE && d_rs_data != d_rt_data);
  always_comb begin
    next_pc = taken ? br_tgt :
              (op == OP_J || op == OP_JAL) ? {base[31:28], instr_q[IDX_W-1:0], 2'b00} :
              (op == OP_SPECIAL && fn == FN_JR) ? d_rs_data :
              f_pc + 32'd4;
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: vector table through a scoreboard queue, plus hand-written reset/stall/GRF sequences.
module tb_id_stage;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0;
  logic [31:0] f_instr = '0, f_pc = '0, w_data = '0, m_fwd_data = '0;
  logic w_we = 1'b0, m_fwd_we = 1'b0;
  logic [4:0] w_addr = '0, m_fwd_addr = '0;
  logic [31:0] d_instr, d_pc, d_rs_data, d_rt_data, next_pc;
  int n_cmp = 0, n_bad = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .f_instr(f_instr), .f_pc(f_pc),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .m_fwd_we(m_fwd_we), .m_fwd_addr(m_fwd_addr), .m_fwd_data(m_fwd_data),
    .d_instr(d_instr), .d_pc(d_pc), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, fpc;
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic me; logic [4:0] ma; logic [31:0] md;
    logic [31:0] rs, rt, npc;
  } vec_t;
  typedef struct { logic [31:0] instr, pc, rs, rt, npc; } exp_t;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    f_instr = instr; f_pc = pc; stall = 1'b0; w_we = 1'b0; m_fwd_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d; m_fwd_we = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1 w_we = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    load(v.instr, v.pc);
    f_pc = v.fpc; w_we = v.we; w_addr = v.wa; w_data = v.wd;
    m_fwd_we = v.me; m_fwd_addr = v.ma; m_fwd_data = v.md;
    sb.push_back('{v.instr, v.pc, v.rs, v.rt, v.npc});
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d d_instr", idx), d_instr, e.instr);
    chk($sformatf("v%0d d_pc", idx), d_pc, e.pc);
    chk($sformatf("v%0d rs", idx), d_rs_data, e.rs);
    chk($sformatf("v%0d rt", idx), d_rt_data, e.rt);
    chk($sformatf("v%0d next_pc", idx), next_pc, e.npc);
  endtask

  initial begin
    //            instr          pc             fpc            we wa  wd            me ma  md            rs            rt            npc
    vecs[0]  = '{32'h0100_0000, 32'h0000_3000, 32'h0000_3004, 1, 8,  32'h1234,     0, 0,  0,            32'h1234,     0,            32'h0000_3008};
    vecs[1]  = '{32'h0000_0000, 32'h0000_3004, 32'h0000_3010, 1, 0,  32'hDEAD,     1, 0,  32'hFFFF,     0,            0,            32'h0000_3014};
    vecs[2]  = '{32'h0100_0000, 32'h0000_3008, 32'h0000_3020, 1, 8,  32'hBBBB,     1, 8,  32'hAAAA,     32'hAAAA,     0,            32'h0000_3024};
    vecs[3]  = '{32'h1022_FFFF, 32'h0000_3008, 32'h0000_300C, 0, 0,  0,            0, 0,  0,            5,            5,            32'h0000_3008};
    vecs[4]  = '{32'h1023_FFFF, 32'h0000_3008, 32'h0000_300C, 0, 0,  0,            0, 0,  0,            5,            7,            32'h0000_3010};
    vecs[5]  = '{32'h1422_FFFF, 32'h0000_3008, 32'h0000_300C, 0, 0,  0,            0, 0,  0,            5,            5,            32'h0000_3010};
    vecs[6]  = '{32'h1423_FFFF, 32'h0000_3008, 32'h0000_300C, 0, 0,  0,            0, 0,  0,            5,            7,            32'h0000_3008};
    vecs[7]  = '{32'h0C00_0C00, 32'h0000_3000, 32'h0000_3004, 0, 0,  0,            0, 0,  0,            0,            0,            32'h0000_3000};
    vecs[8]  = '{32'h03E0_0008, 32'h0000_3010, 32'h0000_3014, 0, 0,  0,            1, 31, 32'h3010,     32'h3010,     0,            32'h0000_3010};
    vecs[9]  = '{32'h0BFF_FFFF, 32'hF000_0000, 32'h0000_3000, 0, 0,  0,            0, 0,  0,            32'h2000,     32'h2000,     32'hFFFF_FFFC};
    vecs[10] = '{32'h1000_0001, 32'hFFFF_FFFC, 32'h0000_3000, 0, 0,  0,            0, 0,  0,            0,            0,            32'h0000_0004};
    vecs[11] = '{32'h1023_FFFF, 32'h0000_3008, 32'h0000_300C, 1, 3,  5,            0, 0,  0,            5,            5,            32'h0000_3008};

    // reset held for two cycles
    f_pc = 32'h0000_3000; f_instr = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst d_instr", d_instr, 32'h0);
    chk("rst d_pc", d_pc, 32'h0000_3000);
    chk("rst next_pc", next_pc, 32'h0000_3004);
    @(negedge clk) reset = 1'b1;

    wr(1, 5); wr(2, 5); wr(3, 7); wr(31, 32'h2000);
    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // stall freezes IF/ID; reset overrides stall
    load(32'h0C00_0C00, 32'h0000_3040);
    @(negedge clk);
    stall = 1'b1; f_instr = 32'hFFFF_FFFF; f_pc = 32'h0000_4000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d d_instr", c), d_instr, 32'h0C00_0C00);
      chk($sformatf("stall%0d d_pc", c), d_pc, 32'h0000_3040);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("stallrst d_instr", d_instr, 32'h0);
    chk("stallrst d_pc", d_pc, 32'h0000_3000);
    chk("stallrst next_pc", next_pc, 32'h0000_4004);
    @(negedge clk) begin reset = 1'b1; stall = 1'b0; end

    // fill the GRF, confirm, then reset mid-operation and read everything back as 0
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 | i);
    load({6'b0, 5'd17, 5'd30, 16'h0}, 32'h0000_3000);
    chk("fill rs17", d_rs_data, 32'hA5A5_0011);
    chk("fill rt30", d_rt_data, 32'hA5A5_001E);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load({6'b0, 5'(i), 5'(i), 16'h0}, 32'h0000_3000);
      chk($sformatf("clr rs%0d", i), d_rs_data, 32'h0);
      chk($sformatf("clr rt%0d", i), d_rt_data, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
